// File: rtl/registro_tiempo_crono_vga.sv
// BCD time-field register bank for the chronometer VGA path: shadow writes are committed
// atomically on frame_sync. Optional legality check enabled by defining BCD_CHECK_EN.
module registro_tiempo_crono_vga #(
    parameter int             NUM_CH  = 3,
    parameter int             W       = 8,
    parameter logic [W-1:0]   MAX_LO  = 8'h59,
    parameter logic [W-1:0]   MAX_TOP = 8'h23,
    localparam int            CSW     = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                seleccion,
    input  logic                EN_deco,
    input  logic                EN,
    input  logic                ACT,
    input  logic [CSW-1:0]      ch_sel,
    input  logic [W-1:0]        dato_in,
    input  logic                frame_sync,
    output logic [NUM_CH*W-1:0] dato_out,
    output logic                pend,
    output logic                err
);

`ifdef BCD_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_COMMIT} state_t;

    state_t                    r_state, w_state_nxt;
    logic [NUM_CH-1:0][W-1:0]  r_shadow;
    logic [NUM_CH-1:0]         r_dirty, w_dirty_nxt;
    logic [NUM_CH*W-1:0]       r_out;
    logic                      r_err;

    logic w_wr, w_in_range, w_is_top, w_bcd_ok, w_legal, w_accept;

    assign w_wr       = EN_deco & ((EN & ~seleccion) | (ACT & seleccion));
    assign w_in_range = (32'(ch_sel) < NUM_CH);
    assign w_is_top   = (32'(ch_sel) == NUM_CH - 1);
    assign w_bcd_ok   = (dato_in[7:4] <= 4'd9) && (dato_in[3:0] <= 4'd9) &&
                        (dato_in <= (w_is_top ? MAX_TOP : MAX_LO));
    assign w_legal    = !CHECK || w_bcd_ok;
    assign w_accept   = w_wr & w_in_range & w_legal;

    // A write landing on the commit edge must survive the dirty clear, so set wins.
    always_comb begin
        // NOTE: defaults first so every path assigns these and no latch is inferred.
        w_dirty_nxt = r_dirty;
        w_state_nxt = r_state;
        if (r_state == S_COMMIT)
            w_dirty_nxt = '0;
        if (w_accept)
            w_dirty_nxt[ch_sel] = 1'b1;

        case (r_state)
            S_IDLE:   if (|r_dirty)   w_state_nxt = S_PEND;
            S_PEND:   if (frame_sync) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = (|w_dirty_nxt) ? S_PEND : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so the commit copies the pre-edge shadow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_dirty  <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dirty <= w_dirty_nxt;
            r_err   <= w_wr & ~(w_in_range & w_legal);
            if (w_accept)
                r_shadow[ch_sel] <= dato_in;
            if (r_state == S_COMMIT) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (r_dirty[i])
                        r_out[i*W +: W] <= r_shadow[i];
                end
            end
        end
    end

    assign dato_out = r_out;
    assign pend     = |r_dirty;
    assign err      = r_err;

endmodule

// File: tb/tb_registro_tiempo_crono_vga.sv
// Self-checking bench for registro_tiempo_crono_vga: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_registro_tiempo_crono_vga;

    localparam int NUM_CH = 3;
    localparam int W      = 8;
    localparam int CSW    = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                seleccion, EN_deco, EN, ACT, frame_sync;
    logic [CSW-1:0]      ch_sel;
    logic [W-1:0]        dato_in;
    logic [NUM_CH*W-1:0] dato_out;
    logic                pend, err;

    always #5 clk = ~clk;

    registro_tiempo_crono_vga #(.NUM_CH(NUM_CH), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .seleccion  (seleccion),
        .EN_deco    (EN_deco),
        .EN         (EN),
        .ACT        (ACT),
        .ch_sel     (ch_sel),
        .dato_in    (dato_in),
        .frame_sync (frame_sync),
        .dato_out   (dato_out),
        .pend       (pend),
        .err        (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-field shadow/committed values plus two flags saying whether
    // a frame_sync would be noticed now and whether the copy happens on this edge.
    logic [W-1:0] m_shadow [NUM_CH];
    logic [W-1:0] m_out    [NUM_CH];
    bit           m_dirty  [NUM_CH];
    bit           m_err, m_watch, m_copy;
    bit           cmp_en = 1'b0;

    function automatic bit legal_model(input int ch, input int d);
`ifdef BCD_CHECK_EN
        int limit;
        limit = (ch == NUM_CH - 1) ? 'h23 : 'h59;
        return ((d / 16) <= 9) && ((d % 16) <= 9) && (d <= limit);
`else
        return (ch >= 0) && (d >= 0);
`endif
    endfunction

    function automatic bit any_dirty();
        bit a = 1'b0;
        for (int i = 0; i < NUM_CH; i++) a |= m_dirty[i];
        return a;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_shadow[i] = '0; m_out[i] = '0; m_dirty[i] = 1'b0;
            end
            m_err = 1'b0; m_watch = 1'b0; m_copy = 1'b0;
            cmp_en <= 1'b1;
        end else begin
            bit wr, ok, had_dirty, next_watch;
            wr = EN_deco && (seleccion ? ACT : EN);
            ok = (int'(ch_sel) < NUM_CH) && legal_model(int'(ch_sel), int'(dato_in));
            had_dirty = any_dirty();
            if (m_copy) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_dirty[i]) begin
                        m_out[i]   = m_shadow[i];
                        m_dirty[i] = 1'b0;
                    end
                end
            end
            if (wr && ok) begin
                m_shadow[ch_sel] = dato_in;
                m_dirty[ch_sel]  = 1'b1;
            end
            m_err = wr && !ok;
            if (m_copy)       next_watch = any_dirty();
            else if (m_watch) next_watch = !frame_sync;
            else              next_watch = had_dirty;
            m_copy  = m_watch && frame_sync;
            m_watch = next_watch;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NUM_CH*W-1:0] exp_out;
            for (int i = 0; i < NUM_CH; i++) exp_out[i*W +: W] = m_out[i];
            check("model_dato_out", 32'(dato_out), 32'(exp_out));
            check("model_pend", 32'(pend), 32'(any_dirty()));
            check("model_err", 32'(err), 32'(m_err));
        end
    end

    task automatic idle_inputs();
        seleccion = 1'b0; EN_deco = 1'b0; EN = 1'b0; ACT = 1'b0;
        ch_sel = '0; dato_in = '0; frame_sync = 1'b0;
    endtask

    task automatic write(input bit sel, input bit en, input bit act,
                         input logic [CSW-1:0] ch, input logic [W-1:0] d);
        EN_deco = 1'b1; seleccion = sel; EN = en; ACT = act; ch_sel = ch; dato_in = d;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic pulse_fs();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        wait_cyc(2);
        reset = 1'b1;

        // Reset in the middle of a pending commit discards everything.
        write(0, 1, 0, 2'd0, 8'h33);
        wait_cyc(3);
        check("pend_before_reset", 32'(pend), 32'd1);
        reset = 1'b0;
        wait_cyc(2);
        check("reset_dato_out", 32'(dato_out), 32'h0);
        check("reset_pend", 32'(pend), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset = 1'b1;
        pulse_fs();
        wait_cyc(2);
        check("fs_ignored_idle", 32'(dato_out), 32'h0);

        // Edit-path write, commit two edges after frame_sync.
        write(0, 1, 0, 2'd0, 8'h42);
        wait_cyc(9);
        pulse_fs();
        check("ch0_before_commit", 32'(dato_out[7:0]), 32'h00);
        check("pend_before_commit", 32'(pend), 32'd1);
        wait_cyc(1);
        check("ch0_after_commit", 32'(dato_out[7:0]), 32'h42);
        check("pend_after_commit", 32'(pend), 32'd0);

        // RTC path: EN ignored when seleccion=1.
        write(1, 1, 1, 2'd2, 8'h17);
        wait_cyc(3);
        pulse_fs();
        wait_cyc(1);
        check("rtc_field2", 32'(dato_out[23:16]), 32'h17);
        write(1, 1, 0, 2'd2, 8'h55);
        check("rtc_no_act_pend", 32'(pend), 32'd0);
        check("rtc_no_act_err", 32'(err), 32'd0);

        // Out-of-range channel.
        write(0, 1, 0, 2'd3, 8'h12);
        check("chsel3_err", 32'(err), 32'd1);
        check("chsel3_pend", 32'(pend), 32'd0);
        wait_cyc(1);
        check("err_one_cycle", 32'(err), 32'd0);
`ifdef BCD_CHECK_EN
        write(0, 1, 0, 2'd2, 8'h24);
        check("top_over_err", 32'(err), 32'd1);
        check("top_over_pend", 32'(pend), 32'd0);
        write(0, 1, 0, 2'd1, 8'h5A);
        check("nibble_err", 32'(err), 32'd1);
        check("nibble_pend", 32'(pend), 32'd0);
        wait_cyc(1);
`endif

        // Write during the commit cycle stays pending.
        write(0, 1, 0, 2'd0, 8'h11);
        wait_cyc(3);
        pulse_fs();
        write(0, 1, 0, 2'd0, 8'h22);
        check("commit_race_ch0", 32'(dato_out[7:0]), 32'h11);
        check("commit_race_pend", 32'(pend), 32'd1);
        wait_cyc(3);
        pulse_fs();
        wait_cyc(1);
        check("second_commit_ch0", 32'(dato_out[7:0]), 32'h22);
        check("second_commit_pend", 32'(pend), 32'd0);

        // Last write wins; both fields land on one edge.
        write(0, 1, 0, 2'd0, 8'h05);
        write(0, 1, 0, 2'd0, 8'h06);
        write(0, 1, 0, 2'd1, 8'h30);
        wait_cyc(3);
        pulse_fs();
        check("batch_before", 32'(dato_out), 32'h170022);
        wait_cyc(1);
        check("batch_after", 32'(dato_out), 32'h173006);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) != 0);
            seleccion  = 1'($urandom_range(0, 1));
            EN_deco    = ($urandom_range(0, 3) != 0);
            EN         = 1'($urandom_range(0, 1));
            ACT        = 1'($urandom_range(0, 1));
            ch_sel     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) != 0)
                dato_in = 8'(($urandom_range(0, 5) << 4) | $urandom_range(0, 9));
            else
                dato_in = 8'($urandom_range(0, 255));
            frame_sync = ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        reset = 1'b1;
        idle_inputs();
        wait_cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
